tbird_tail_light: RTL and testbench



---
 rtl/tbird_tail_light.sv | 138 +++++++++++++
 tb/tb_tbird_tail_light.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tbird_tail_light.sv
// Thunderbird tail-light sequencer: prescaled step tick drives a
// Moore FSM for left, right and hazard lamp patterns, code on HEX0.
//   ADC_CLK_10 : board clock
//   KEY[0]     : async reset, active-low; KEY[1]: pause, active-low
//   SW[1:0]    : mode (00 off, 01 left, 10 right, 11 hazard)
//   LEDR       : lamps LC LB LA at 9:7, RA RB RC at 2:0
//   HEX0       : state code digit, active-low, dp off
module tbird_tail_light #(
   parameter int DIV = 2_500_000
) (
   input  logic       ADC_CLK_10,
   input  logic [1:0] KEY,
   input  logic [9:0] SW,
   output logic [7:0] HEX0,
   output logic [9:0] LEDR
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      L1   = 3'd1,
      L2   = 3'd2,
      L3   = 3'd3,
      R1   = 3'd4,
      R2   = 3'd5,
      R3   = 3'd6,
      LR3  = 3'd7
   } state_t;

   logic          arst_n;
   logic [1:0]    rst_sync;
   logic          rst_n;
   logic [1:0]    mode_s1;
   logic [1:0]    mode;
   logic          run_s1;
   logic          run;
   logic [CW-1:0] cnt;
   logic          tick;
   logic          haz;
   state_t        state;
   state_t        nxt;
   logic [2:0]    left;
   logic [2:0]    right;
   logic          unused_sw;

   assign arst_n    = KEY[0];
   assign unused_sw = ^SW[9:2];

   // Reset asserts at once, releases two edges after KEY[0] rises.
   always_ff @(posedge ADC_CLK_10 or negedge arst_n) begin
      if (!arst_n) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1 <= 2'b00;
         mode    <= 2'b00;
         run_s1  <= 1'b1;
         run     <= 1'b1;
      end else begin
         mode_s1 <= SW[1:0];
         mode    <= mode_s1;
         run_s1  <= KEY[1];
         run     <= run_s1;
      end
   end

   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (run)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign tick = run && (cnt == LAST);
   assign haz  = (mode == 2'b11);

   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (tick) begin
         unique case (state)
            IDLE: begin
               unique case (mode)
                  2'b01:   nxt = L1;
                  2'b10:   nxt = R1;
                  2'b11:   nxt = LR3;
                  default: nxt = IDLE;
               endcase
            end
            L1:      nxt = haz ? LR3 : L2;
            L2:      nxt = haz ? LR3 : L3;
            L3:      nxt = haz ? LR3 : IDLE;
            R1:      nxt = haz ? LR3 : R2;
            R2:      nxt = haz ? LR3 : R3;
            R3:      nxt = haz ? LR3 : IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // left = {LC,LB,LA}, right = {RA,RB,RC}
   always_comb begin
      left  = 3'b000;
      right = 3'b000;
      HEX0  = 8'hC0;
      unique case (state)
         L1:  begin left  = 3'b001; HEX0 = 8'hF9; end
         L2:  begin left  = 3'b011; HEX0 = 8'hA4; end
         L3:  begin left  = 3'b111; HEX0 = 8'hB0; end
         R1:  begin right = 3'b100; HEX0 = 8'h99; end
         R2:  begin right = 3'b110; HEX0 = 8'h92; end
         R3:  begin right = 3'b111; HEX0 = 8'h82; end
         LR3: begin
            left  = 3'b111;
            right = 3'b111;
            HEX0  = 8'hF8;
         end
         default: begin
            left  = 3'b000;
            right = 3'b000;
            HEX0  = 8'hC0;
         end
      endcase
   end

   assign LEDR = {left, 4'b0000, right};

endmodule

// File: tb/tb_tbird_tail_light.sv
// Bench for tbird_tail_light: directed and random key/switch
// segments, lamps and display checked against a reference model.
module tb_tbird_tail_light;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic [1:0] key;
   logic [9:0] sw;
   logic [7:0] hex;
   logic [9:0] ledr;

   int n_cmp = 0;
   int n_bad = 0;

   tbird_tail_light #(.DIV(DIV)) dut (
      .ADC_CLK_10 (clk),
      .KEY        (key),
      .SW         (sw),
      .HEX0       (hex),
      .LEDR       (ledr)
   );

   always #5 clk = ~clk;

   // Model: side 0 none, 1 left, 2 right, 3 hazard; lit = lamps per side.
   int         age;
   int         phase;
   int         side;
   int         lit;
   logic [1:0] mq[$];
   logic       pq[$];
   logic [7:0] segs [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                            8'h99, 8'h92, 8'h82, 8'hF8};

   task automatic chk(input string tag,
                      input logic [9:0] got,
                      input logic [9:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      age   = 0;
      phase = 0;
      side  = 0;
      lit   = 0;
      mq    = '{2'b00, 2'b00};
      pq    = '{1'b1, 1'b1};
   endfunction

   function automatic void m_step(input logic [1:0] m);
      if (side == 3) begin
         side = 0; lit = 0;
      end else if (m == 2'b11) begin
         side = 3; lit = 3;
      end else if (lit == 0) begin
         if (m != 2'b00) begin
            side = int'(m); lit = 1;
         end
      end else if (lit == 3) begin
         side = 0; lit = 0;
      end else begin
         lit++;
      end
   endfunction

   function automatic void m_edge();
      logic [1:0] vm;
      logic       vr;
      if (!key[0]) begin
         m_reset();
         return;
      end
      if (age < 2) begin
         age++;
         return;
      end
      vm = mq.pop_front();
      vr = pq.pop_front();
      mq.push_back(sw[1:0]);
      pq.push_back(key[1]);
      if (vr) begin
         if (phase == DIV - 1) m_step(vm);
         phase = (phase + 1) % DIV;
      end
   endfunction

   function automatic logic [9:0] exp_led();
      logic [9:0] l;
      l = '0;
      if (side == 1 || side == 3) begin
         l[7] = lit >= 1;
         l[8] = lit >= 2;
         l[9] = lit >= 3;
      end
      if (side == 2 || side == 3) begin
         l[2] = lit >= 1;
         l[1] = lit >= 2;
         l[0] = lit >= 3;
      end
      return l;
   endfunction

   function automatic logic [7:0] exp_hex();
      int c;
      if (side == 3)      c = 7;
      else if (side == 1) c = lit;
      else if (side == 2) c = 3 + lit;
      else                c = 0;
      return segs[c];
   endfunction

   task automatic check_out(input string when);
      chk({"ledr ", when}, ledr, exp_led());
      chk({"hex ", when}, {2'b00, hex}, {2'b00, exp_hex()});
   endtask

   task automatic step(input logic [1:0] k, input logic [9:0] s);
      @(negedge clk);
      key = k;
      sw  = s;
      if (!k[0]) m_reset();
      #1 check_out("neg");
      @(posedge clk);
      m_edge();
      #1 check_out("pos");
   endtask

   task automatic hold(input logic [1:0] k,
                       input logic [9:0] s,
                       input int n);
      repeat (n) step(k, s);
   endtask

   initial begin
      key = 2'b11;
      sw  = '0;
      m_reset();
      hold(2'b10, 10'd0, 5);
      hold(2'b11, 10'd0, 6);
      hold(2'b11, 10'b0000000010, 20);
      hold(2'b11, 10'b0000000001, 20);
      hold(2'b11, 10'b0000000011, 16);
      hold(2'b11, 10'b0000000000, 6);
      hold(2'b11, 10'b0000000010, 10);
      hold(2'b11, 10'b0000000011, 8);
      hold(2'b11, 10'b0000000010, 9);
      hold(2'b01, 10'b0000000010, 20);
      hold(2'b11, 10'b0000000010, 10);
      hold(2'b11, 10'b0000000001, 14);
      // KEY[0] falls while the clock is high, between edges.
      #3 key[0] = 1'b0;
      m_reset();
      #1 check_out("async");
      hold(2'b00, 10'b0000000001, 5);
      hold(2'b11, 10'd0, 4);
      repeat (80) begin
         int r;
         logic [1:0] k;
         r = int'($urandom_range(0, 15));
         if (r < 2)      k = 2'b01;
         else if (r < 3) k = 2'b10;
         else            k = 2'b11;
         hold(k, 10'($urandom), int'($urandom_range(1, 12)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
